// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing an asynchronous instruction ROM between fetch and data ports
module rom_arbiter #(
    parameter int tam_entrada = 10,
    parameter int tam_salida  = 32,
    parameter int CNT_W       = 16
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   i_req,
    input  logic [31:0]            i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [tam_salida-1:0]  i_rdata,
    output logic                   i_err,
    input  logic                   d_req,
    input  logic [31:0]            d_addr,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [tam_salida-1:0]  d_rdata,
    output logic                   d_err,
    output logic [tam_entrada-1:0] rom_addr,
    input  logic [tam_salida-1:0]  rom_data,
    output logic [CNT_W-1:0]       conflict_cnt
);

    typedef enum logic {
        PRIO_I = 1'b0,
        PRIO_D = 1'b1
    } prio_e;

    prio_e                  prio_q, prio_d;
    logic                   conflict;
    logic                   grant_any;
    logic [31:0]            sel_addr;
    logic                   sel_err;
    logic [tam_salida-1:0]  resp_data;
    logic [tam_entrada-1:0] rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   i_rvalid_q, d_rvalid_q;
    logic [tam_salida-1:0]  i_rdata_q, d_rdata_q;
    logic                   i_err_q, d_err_q;

    // Arbitration, address translation/check and next-state for prio and the conflict counter
    always_comb begin
        conflict   = i_req & d_req;
        // Grants are forced low while reset is asserted so no request is accepted then
        i_gnt      = RST_n & i_req & (~d_req | (prio_q == PRIO_I));
        d_gnt      = RST_n & d_req & (~i_req | (prio_q == PRIO_D));
        grant_any  = i_gnt | d_gnt;
        sel_addr   = d_gnt ? d_addr : i_addr;
        sel_err    = (sel_addr[1:0] != 2'b00) || (sel_addr[31:tam_entrada+2] != '0);
        resp_data  = sel_err ? '0 : rom_data;
        // The ROM keeps seeing the last granted word when nobody is granted
        rom_addr_d = grant_any ? sel_addr[tam_entrada+1:2] : rom_addr_q;
        rom_addr   = rom_addr_d;
        prio_d     = prio_q;
        if (conflict) begin
            prio_d = (prio_q == PRIO_I) ? PRIO_D : PRIO_I;
        end
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register: prio pointer, held ROM address, counter and per-port response registers
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            prio_q     <= PRIO_I;
            rom_addr_q <= '0;
            cnt_q      <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            rom_addr_q <= rom_addr_d;
            cnt_q      <= cnt_d;
            i_rvalid_q <= i_gnt;
            d_rvalid_q <= d_gnt;
            if (i_gnt) begin
                i_rdata_q <= resp_data;
                i_err_q   <= sel_err;
            end
            if (d_gnt) begin
                d_rdata_q <= resp_data;
                d_err_q   <= sel_err;
            end
        end
    end

    assign i_rvalid     = i_rvalid_q;
    assign i_rdata      = i_rdata_q;
    assign i_err        = i_err_q;
    assign d_rvalid     = d_rvalid_q;
    assign d_rdata      = d_rdata_q;
    assign d_err        = d_err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
module tb_rom_arbiter;

    localparam int TE        = 10;
    localparam int TS        = 32;
    localparam int DEPTH     = 1 << TE;
    localparam longint ROM_BYTES = 4 * DEPTH;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic          i_req, d_req;
    logic [31:0]   i_addr, d_addr;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err;
    logic [TS-1:0] i_rdata, d_rdata, rom_data;
    logic [TE-1:0] rom_addr;
    logic [15:0]   conflict_cnt;

    logic          i_gnt4, d_gnt4, i_rvalid4, d_rvalid4, i_err4, d_err4;
    logic [TS-1:0] i_rdata4, d_rdata4, rom_data4;
    logic [TE-1:0] rom_addr4;
    logic [3:0]    conflict_cnt4;

    logic [TS-1:0] rom_mem [0:DEPTH-1];

    assign rom_data  = rom_mem[rom_addr];
    assign rom_data4 = rom_mem[rom_addr4];

    always #5 CLK = ~CLK;

    rom_arbiter #(.tam_entrada(TE), .tam_salida(TS), .CNT_W(16)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .rom_addr(rom_addr), .rom_data(rom_data), .conflict_cnt(conflict_cnt)
    );

    rom_arbiter #(.tam_entrada(TE), .tam_salida(TS), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST_n(RST_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt4), .i_rvalid(i_rvalid4), .i_rdata(i_rdata4), .i_err(i_err4),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4), .d_err(d_err4),
        .rom_addr(rom_addr4), .rom_data(rom_data4), .conflict_cnt(conflict_cnt4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit            m_d_wins;
    int            m_cnt, m_cnt4;
    int            m_rom_addr;
    bit            m_i_rv, m_d_rv, m_i_err, m_d_err;
    logic [TS-1:0] m_i_rd, m_d_rd;

    // DUT values captured during the last step
    bit            cap_ig, cap_dg, cap_irv, cap_drv, cap_err;
    int            cap_cnt;
    bit            last_gi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                        input bit dr, input logic [31:0] da);
        bit            gi, gd, e;
        logic [31:0]   a;
        logic [TS-1:0] data;
        @(negedge CLK);
        RST_n  = rst;
        i_req  = ir;
        i_addr = ia;
        d_req  = dr;
        d_addr = da;
        #1;
        gi = 1'b0;
        gd = 1'b0;
        if (rst) begin
            if (ir && dr) begin
                gi = !m_d_wins;
                gd = m_d_wins;
            end else begin
                gi = ir;
                gd = dr;
            end
        end
        a    = gd ? da : ia;
        e    = (a % 4 != 0) || (longint'(a) >= ROM_BYTES);
        data = e ? '0 : rom_mem[(a / 4) % DEPTH];
        if (gi || gd) m_rom_addr = (a / 4) % DEPTH;
        chk("i_gnt", i_gnt, gi);
        chk("d_gnt", d_gnt, gd);
        chk("i_gnt4", i_gnt4, gi);
        chk("d_gnt4", d_gnt4, gd);
        if (rst) begin
            chk("rom_addr", rom_addr, m_rom_addr);
            chk("rom_addr4", rom_addr4, m_rom_addr);
        end
        cap_ig = i_gnt;
        cap_dg = d_gnt;
        if (!rst) begin
            m_d_wins = 1'b0; m_cnt = 0; m_cnt4 = 0; m_rom_addr = 0;
            m_i_rv = 1'b0; m_d_rv = 1'b0; m_i_err = 1'b0; m_d_err = 1'b0;
            m_i_rd = '0; m_d_rd = '0;
        end else begin
            if (ir && dr) begin
                m_d_wins = !m_d_wins;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_i_rv = gi;
            m_d_rv = gd;
            if (gi) begin m_i_rd = data; m_i_err = e; end
            if (gd) begin m_d_rd = data; m_d_err = e; end
        end
        last_gi = gi;
        @(posedge CLK);
        #1;
        chk("i_rvalid", i_rvalid, m_i_rv);
        chk("d_rvalid", d_rvalid, m_d_rv);
        chk("i_rdata", i_rdata, m_i_rd);
        chk("d_rdata", d_rdata, m_d_rd);
        chk("i_err", i_err, m_i_err);
        chk("d_err", d_err, m_d_err);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("conflict_cnt4", conflict_cnt4, m_cnt4);
        chk("i_rvalid4", i_rvalid4, m_i_rv);
        chk("d_rdata4", d_rdata4, m_d_rd);
        cap_irv = i_rvalid;
        cap_drv = d_rvalid;
        cap_err = i_rvalid ? i_err : d_err;
        cap_cnt = int'(conflict_cnt);
    endtask

    typedef struct {
        bit          rst;
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        logic [31:0] da;
        bit          e_ig, e_dg, e_irv, e_drv, e_err;
        int          e_cnt;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
        if (sel == 1) return $urandom | 32'h0000_1000;
        return $urandom_range(0, DEPTH - 1) << 2;
    endfunction

    initial begin
        bit            ir, dr;
        logic [31:0]   ia, da;

        for (int k = 0; k < DEPTH; k++) rom_mem[k] = $urandom | 32'h1;
        RST_n = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;

        //          rst ir ia            dr da            ig dg irv drv err cnt
        vecs[0]  = '{0, 1, 32'h0000_0008, 1, 32'h0000_000C, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 32'h0000_0008, 1, 32'h0000_000C, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 32'h0000_0008, 0, 32'h0000_0000, 1, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 32'h0000_0004, 1, 32'h0000_000C, 1, 0, 1, 0, 0, 1};
        vecs[4]  = '{1, 1, 32'h0000_0004, 1, 32'h0000_000C, 0, 1, 0, 1, 0, 2};
        vecs[5]  = '{1, 1, 32'h0000_0004, 1, 32'h0000_000C, 1, 0, 1, 0, 0, 3};
        vecs[6]  = '{1, 1, 32'h0000_0004, 1, 32'h0000_000C, 0, 1, 0, 1, 0, 4};
        vecs[7]  = '{1, 0, 32'h0000_0000, 1, 32'h0000_0006, 0, 1, 0, 1, 1, 4};
        vecs[8]  = '{1, 0, 32'h0000_0000, 1, 32'h0000_1000, 0, 1, 0, 1, 1, 4};
        vecs[9]  = '{1, 0, 32'h0000_0000, 1, 32'h0000_0FFC, 0, 1, 0, 1, 0, 4};
        vecs[10] = '{1, 1, 32'h0000_0004, 0, 32'h0000_0000, 1, 0, 1, 0, 0, 4};
        vecs[11] = '{1, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 4};

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].rst, vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].da);
            chk($sformatf("vec%0d_i_gnt", v), cap_ig, vecs[v].e_ig);
            chk($sformatf("vec%0d_d_gnt", v), cap_dg, vecs[v].e_dg);
            chk($sformatf("vec%0d_i_rvalid", v), cap_irv, vecs[v].e_irv);
            chk($sformatf("vec%0d_d_rvalid", v), cap_drv, vecs[v].e_drv);
            chk($sformatf("vec%0d_err", v), cap_err, vecs[v].e_err);
            chk($sformatf("vec%0d_cnt", v), cap_cnt, vecs[v].e_cnt);
        end
        chk("rom_word_1023", d_rdata, rom_mem[1023]);

        // reset mid-operation: prio moves to D, reset drops the request, I wins again after
        step(1, 1, 32'h4, 1, 32'hC);
        chk("midop_pre_i_gnt", cap_ig, 1);
        step(0, 1, 32'h4, 1, 32'hC);
        chk("midop_rst_i_gnt", cap_ig, 0);
        chk("midop_rst_i_rvalid", cap_irv, 0);
        step(1, 1, 32'h4, 1, 32'hC);
        chk("midop_post_i_gnt", cap_ig, 1);
        chk("midop_post_d_gnt", cap_dg, 0);
        chk("midop_post_i_rdata", i_rdata, rom_mem[1]);

        // saturation of the narrow counter
        for (int c = 0; c < 20; c++) step(1, 1, 32'h4, 1, 32'hC);
        chk("sat_cnt4", conflict_cnt4, 4'd15);
        chk("sat_cnt16", conflict_cnt, 16'd21);

        // randomized traffic against the reference model; ungranted requests are held
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0;
        for (int r = 0; r < 400; r++) begin
            if (!(ir && !last_gi)) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = rand_addr();
            end
            if (!(dr && !cap_dg)) begin
                dr = ($urandom_range(0, 2) != 0);
                da = rand_addr();
            end
            step(($urandom_range(0, 49) != 0), ir, ia, dr, da);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
